apu_pulse_env: RTL and testbench

Parametrised next-generation NES-style pulse channel. Adds a multi-bit volume output, a decaying/looping envelope unit and a configurable mute threshold. Config and period arrive on valid/ready channels. Samples leave on a valid/ready stream with full backpressure, at one sample per tick. Sits behind the pad wrapper and feeds the mixer.

---
 rtl/apu_pulse_env.sv | 90 +++++++++
 tb/tb_apu_pulse_env.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/apu_pulse_env.sv
// apu_pulse_env: NES-style pulse channel with envelope, mute threshold and
// a backpressured sample stream producing one sample per accepted tick.
module apu_pulse_env #(
    parameter int PERIOD_W   = 11,
    parameter int VOL_W      = 4,
    parameter int ENV_DIV    = 256,
    parameter int MIN_PERIOD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_vld,
    output logic                period_rdy,
    input  logic [1:0]          cfg_duty,
    input  logic                cfg_const_vol,
    input  logic                cfg_loop,
    input  logic [VOL_W-1:0]    cfg_vol,
    input  logic                cfg_vld,
    output logic                cfg_rdy,
    output logic [VOL_W-1:0]    out_data,
    output logic                out_vld,
    input  logic                out_rdy
);
    localparam int PW = ENV_DIV > 1 ? $clog2(ENV_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(ENV_DIV - 1);
    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    logic [PERIOD_W-1:0] period_q, timer;
    logic [1:0]          duty;
    logic                const_vol, loop;
    logic [VOL_W-1:0]    vol, decay, env_cnt, amp;
    logic [2:0]          step;
    logic [PW-1:0]       presc;
    logic                tick, env_clk;
    logic [7:0]          row;

    always_comb begin
        tick = !out_vld || out_rdy;
        env_clk = tick && presc == PRESC_MAX;
        row = duty == 2'd0 ? 8'b0000_0010 : duty == 2'd1 ? 8'b0000_0110 :
              duty == 2'd2 ? 8'b0001_1110 : 8'b1111_1001;
        amp = (period_q < MIN_P || !row[step]) ? '0 : (const_vol ? vol : decay);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            out_data   <= '0;
            period_rdy <= 1'b0;
            cfg_rdy    <= 1'b0;
            period_q   <= '0;
            duty       <= '0;
            const_vol  <= 1'b1;
            loop       <= 1'b0;
            vol        <= '0;
            timer      <= '0;
            step       <= '0;
            decay      <= '0;
            env_cnt    <= '0;
            presc      <= '0;
        end else begin
            period_rdy <= 1'b1;
            cfg_rdy    <= 1'b1;
            if (tick) begin
                out_data <= amp;
                out_vld  <= 1'b1;
                timer    <= timer == '0 ? period_q : timer - 1'b1;
                step     <= timer == '0 ? step + 3'd1 : step;
                presc    <= env_clk ? '0 : presc + 1'b1;
                if (env_clk) begin
                    env_cnt <= env_cnt == '0 ? vol : env_cnt - 1'b1;
                    if (env_cnt == '0)
                        decay <= decay != '0 ? decay - 1'b1 : (loop ? '1 : '0);
                end
            end
            if (period_vld && period_rdy)
                period_q <= period;
            // a cfg write restarts the envelope, overriding any same-cycle envelope clock
            if (cfg_vld && cfg_rdy) begin
                duty      <= cfg_duty;
                const_vol <= cfg_const_vol;
                loop      <= cfg_loop;
                vol       <= cfg_vol;
                decay     <= '1;
                env_cnt   <= cfg_vol;
                presc     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_apu_pulse_env.sv
// tb_apu_pulse_env: directed checks of pulse pattern, mute, backpressure,
// envelope decay/loop/rate, cfg collision and async reset.
module tb_apu_pulse_env;
    logic        clk, rst_n;
    logic [10:0] period;
    logic        period_vld, period_rdy;
    logic [1:0]  cfg_duty;
    logic        cfg_const_vol, cfg_loop;
    logic [3:0]  cfg_vol;
    logic        cfg_vld, cfg_rdy;
    logic [3:0]  out_data;
    logic        out_vld, out_rdy;

    int checks = 0;
    int errors = 0;
    int q[$];
    int ref_q[$];

    apu_pulse_env #(.PERIOD_W(11), .VOL_W(4), .ENV_DIV(4), .MIN_PERIOD(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .period(period), .period_vld(period_vld), .period_rdy(period_rdy),
        .cfg_duty(cfg_duty), .cfg_const_vol(cfg_const_vol), .cfg_loop(cfg_loop),
        .cfg_vol(cfg_vol), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a sample seen valid&&ready at negedge is accepted on the next posedge
    always @(negedge clk)
        if (rst_n && out_vld && out_rdy) q.push_back(int'(out_data));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // closed-form expected sample n after a fresh start; b = tick of last cfg write
    function automatic int exp_amp(int n, int p, int d, int cv, int lp, int v, int b);
        int s, k;
        logic [7:0] row;
        if (n == 0 || p < 8) return 0;
        s = n < 2 ? n : (2 + (n - 2) / (p + 1)) % 8;
        row = d == 0 ? 8'b00000010 : d == 1 ? 8'b00000110 : d == 2 ? 8'b00011110 : 8'b11111001;
        if (!row[s]) return 0;
        if (cv != 0) return v;
        k = ((n - b - 1) / 4) / (v + 1);
        return lp != 0 ? 15 - k % 16 : (k > 15 ? 0 : 15 - k);
    endfunction

    task automatic tick_mid();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int n);
        int guard = 0;
        while (q.size() < n && guard < 5000) begin
            tick_mid();
            guard++;
        end
        if (q.size() < n) chk("timeout", q.size(), n);
    endtask

    task automatic start(input int p, input int d, input int cv, input int lp, input int v);
        out_rdy = 0; period_vld = 0; cfg_vld = 0;
        rst_n = 0;
        repeat (5) tick_mid();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_period_rdy", period_rdy, 0);
        chk("rst_cfg_rdy", cfg_rdy, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1;
        tick_mid();
        chk("rel_out_vld", out_vld, 1);
        chk("rel_period_rdy", period_rdy, 1);
        chk("rel_cfg_rdy", cfg_rdy, 1);
        chk("rel_out_data", out_data, 0);
        period = 11'(p); cfg_duty = 2'(d); cfg_const_vol = 1'(cv);
        cfg_loop = 1'(lp); cfg_vol = 4'(v);
        period_vld = 1; cfg_vld = 1;
        tick_mid();
        period_vld = 0; cfg_vld = 0;
        q.delete();
        out_rdy = 1;
    endtask

    task automatic check_run(input string tag, input int p, input int d, input int cv,
                             input int lp, input int v);
        for (int i = 0; i < q.size(); i++) chk(tag, q[i], exp_amp(i, p, d, cv, lp, v, 0));
    endtask

    initial begin
        int e, len;
        rst_n = 0; out_rdy = 0; period = 0; period_vld = 0;
        cfg_duty = 0; cfg_const_vol = 1; cfg_loop = 0; cfg_vol = 0; cfg_vld = 0;

        start(8, 2, 1, 0, 15);
        collect(160);
        check_run("pulse", 8, 2, 1, 0, 15);
        ref_q = q;

        start(8, 2, 1, 0, 15);
        for (int s = 0; s < 10; s++) begin
            repeat ($urandom_range(3, 12)) tick_mid();
            out_rdy = 0;
            len = $urandom_range(1, 12);
            repeat (len) begin
                tick_mid();
                chk("stall_hold", out_data, exp_amp(q.size(), 8, 2, 1, 0, 15, 0));
            end
            out_rdy = 1;
        end
        collect(160);
        for (int i = 0; i < ref_q.size(); i++) chk("stall_seq", q[i], ref_q[i]);

        start(7, 2, 1, 0, 15);
        collect(48);
        out_rdy = 0;
        period = 11'd8; period_vld = 1;
        tick_mid();
        period_vld = 0; out_rdy = 1;
        collect(140);
        for (int i = 0; i < q.size(); i++) begin
            e = (i >= 50 && ((i - 50) / 9) % 8 >= 1 && ((i - 50) / 9) % 8 <= 4) ? 15 : 0;
            chk(i <= 48 ? "mute" : "unmute", q[i], e);
        end

        start(8, 3, 0, 0, 0);
        collect(100);
        check_run("env_decay", 8, 3, 0, 0, 0);

        start(8, 3, 0, 1, 0);
        collect(150);
        check_run("env_loop", 8, 3, 0, 1, 0);

        start(8, 3, 0, 0, 1);
        collect(140);
        check_run("env_half", 8, 3, 0, 0, 1);

        start(8, 3, 0, 0, 0);
        collect(19);
        cfg_vol = 4'd2; cfg_vld = 1;
        tick_mid();
        cfg_vld = 0;
        collect(120);
        for (int i = 0; i < q.size(); i++)
            chk("collide", q[i], i <= 20 ? exp_amp(i, 8, 3, 0, 0, 0, 0) : exp_amp(i, 8, 3, 0, 0, 2, 20));

        #2 rst_n = 0;
        #1;
        chk("async_out_vld", out_vld, 0);
        chk("async_period_rdy", period_rdy, 0);
        chk("async_cfg_rdy", cfg_rdy, 0);
        chk("async_out_data", out_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
